// File: rtl/uart_pkg.sv
// Shared UART definitions: deframer/framer FSM states and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } uart_state_e;

  localparam int unsigned Oversample  = 16;
  localparam int unsigned MidBit      = 7;
  localparam int unsigned DefaultDbit = 8;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line; resets to the idle (high) level.
module rx_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: recovers start/data/parity/stop from 16x ticks and holds one byte.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = DefaultDbit,
  parameter int unsigned OVERSAMPLE = Oversample
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            rx_i,
  input  logic            s_tick_i,
  input  logic            parity_en_i,
  input  logic            parity_odd_i,
  input  logic            rd_uart_i,
  output logic [DBIT-1:0] r_data_o,
  output logic            rx_ready_o,
  output logic            parity_err_o,
  output logic            framing_err_o,
  output logic            overflow_o,
  output logic            busy_o
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  uart_state_e     state_q;
  logic [SW-1:0]   s_cnt_q;
  logic [NW-1:0]   n_cnt_q;
  logic [DBIT-1:0] sreg_q;
  logic            perr_q;
  logic [DBIT-1:0] r_data_q;
  logic            rx_ready_q;
  logic            parity_err_q;
  logic            framing_err_q;
  logic            overflow_q;
  logic            rx;
  logic            last_tick;

  rx_sync u_rx_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (rx_i),
    .q_o     (rx)
  );

  assign last_tick = (s_cnt_q == SW'(OVERSAMPLE - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      s_cnt_q       <= '0;
      n_cnt_q       <= '0;
      sreg_q        <= '0;
      perr_q        <= 1'b0;
      r_data_q      <= '0;
      rx_ready_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (rd_uart_i && rx_ready_q) begin
        rx_ready_q <= 1'b0;
        overflow_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (!rx) begin
            state_q <= StStart;
            s_cnt_q <= '0;
          end
        end
        StStart: begin
          if (s_tick_i) begin
            if (s_cnt_q == SW'(MidBit)) begin
              // A high line at mid start bit is a glitch, not a frame.
              if (!rx) begin
                state_q <= StData;
                s_cnt_q <= '0;
                n_cnt_q <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (s_tick_i) begin
            if (last_tick) begin
              sreg_q  <= {rx, sreg_q[DBIT-1:1]};
              s_cnt_q <= '0;
              if (n_cnt_q == NW'(DBIT - 1)) begin
                perr_q  <= 1'b0;
                state_q <= parity_en_i ? StParity : StStop;
              end else begin
                n_cnt_q <= n_cnt_q + 1'b1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (s_tick_i) begin
            if (last_tick) begin
              perr_q  <= ((^sreg_q) ^ rx) != parity_odd_i;
              s_cnt_q <= '0;
              state_q <= StStop;
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (s_tick_i) begin
            if (last_tick) begin
              s_cnt_q <= '0;
              state_q <= rx ? StIdle : StWaitHigh;
              // A read in the commit cycle frees the holding register for the new byte.
              if (!rx_ready_q || rd_uart_i) begin
                r_data_q      <= sreg_q;
                parity_err_q  <= perr_q;
                framing_err_q <= !rx;
                rx_ready_q    <= 1'b1;
              end else begin
                overflow_q <= 1'b1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        StWaitHigh: begin
          if (rx) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign r_data_o      = r_data_q;
  assign rx_ready_o    = rx_ready_q;
  assign parity_err_o  = parity_err_q;
  assign framing_err_o = framing_err_q;
  assign overflow_o    = overflow_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: frame-level model of the holding register plus literals.
module tb_uart_rx_deframer;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       rx         = 1'b1;
  logic       s_tick     = 1'b0;
  logic       parity_en  = 1'b0;
  logic       parity_odd = 1'b0;
  logic       rd_uart    = 1'b0;
  logic [7:0] r_data;
  logic       rx_ready, parity_err, framing_err, overflow, busy;

  logic [1:0] tdiv = 2'd0;

  logic [7:0] exp_data  = 8'h00;
  logic       exp_ready = 1'b0;
  logic       exp_perr  = 1'b0;
  logic       exp_ferr  = 1'b0;
  logic       exp_ovf   = 1'b0;
  logic       exp_busy  = 1'b0;
  logic       check_en  = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  uart_rx_deframer #(
    .DBIT       (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .rx_i          (rx),
    .s_tick_i      (s_tick),
    .parity_en_i   (parity_en),
    .parity_odd_i  (parity_odd),
    .rd_uart_i     (rd_uart),
    .r_data_o      (r_data),
    .rx_ready_o    (rx_ready),
    .parity_err_o  (parity_err),
    .framing_err_o (framing_err),
    .overflow_o    (overflow),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // One-cycle tick every 4 clocks.
  always @(posedge clk) begin
    tdiv   <= tdiv + 2'd1;
    s_tick <= (tdiv == 2'd2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("r_data", {24'd0, r_data}, {24'd0, exp_data});
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, exp_ready});
      chk("parity_err", {31'd0, parity_err}, {31'd0, exp_perr});
      chk("framing_err", {31'd0, framing_err}, {31'd0, exp_ferr});
      chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    end
  end

  function automatic logic frame_perr(input logic [7:0] d, input logic pbit);
    return parity_en && (((^d) ^ pbit) != parity_odd);
  endfunction

  task automatic model_commit(input logic [7:0] d, input logic perr, input logic ferr,
                              input logic rd_same);
    if (!exp_ready || rd_same) begin
      exp_data  = d;
      exp_perr  = perr;
      exp_ferr  = ferr;
      exp_ready = 1'b1;
      exp_ovf   = 1'b0;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_data  = 8'h00;
    exp_ready = 1'b0;
    exp_perr  = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovf   = 1'b0;
    exp_busy  = 1'b0;
  endtask

  // All stimulus tasks begin and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    drive_bit(1'b0, 64);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 64);
    if (parity_en) drive_bit(pbit, 64);
    drive_bit(stop, 64);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic pbit, input logic stop);
    send_frame(d, pbit, stop);
    model_commit(d, frame_perr(d, pbit), !stop, 1'b0);
  endtask

  task automatic do_read();
    rd_uart = 1'b1;
    @(posedge clk);
    #1;
    rd_uart = 1'b0;
    if (exp_ready) begin
      exp_ready = 1'b0;
      exp_ovf   = 1'b0;
    end
  endtask

  task automatic window(input int n);
    check_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check_en = 1'b0;
  endtask

  // Start edge seen 2 clocks after the pin; stop sample is tick 8+16*8+15 = 151 thereafter.
  task automatic rd_at_commit();
    int n = 0;
    repeat (3) @(posedge clk);
    while (n < 200) begin
      @(negedge clk);
      if (s_tick) begin
        if (n == 151) begin
          rd_uart = 1'b1;
          @(negedge clk);
          rd_uart = 1'b0;
          n = 200;
        end else begin
          n++;
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("reset_ready", {31'd0, rx_ready}, 32'd0);
    chk("reset_data", {24'd0, r_data}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    window(5);

    // Plain 8N1 frame.
    rx_frame(8'hA5, 1'b0, 1'b1);
    window(8);
    chk("a5_data", {24'd0, r_data}, 32'hA5);
    chk("a5_ready", {31'd0, rx_ready}, 32'd1);
    do_read();
    window(4);

    // Parity: 0x3C has even weight.
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    rx_frame(8'h3C, 1'b1, 1'b1);
    window(8);
    chk("3c_bad_perr", {31'd0, parity_err}, 32'd1);
    chk("3c_bad_data", {24'd0, r_data}, 32'h3C);
    do_read();
    rx_frame(8'h3C, 1'b0, 1'b1);
    window(8);
    chk("3c_good_perr", {31'd0, parity_err}, 32'd0);
    do_read();
    parity_odd = 1'b1;
    rx_frame(8'h3C, 1'b1, 1'b1);
    window(8);
    chk("3c_odd_perr", {31'd0, parity_err}, 32'd0);
    do_read();
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // Break: stop low and line held low for 40 more ticks.
    rx_frame(8'h55, 1'b0, 1'b0);
    exp_busy = 1'b1;
    check_en = 1'b1;
    drive_bit(1'b0, 160);
    check_en = 1'b0;
    chk("brk_ferr", {31'd0, framing_err}, 32'd1);
    chk("brk_busy", {31'd0, busy}, 32'd1);
    chk("brk_ovf", {31'd0, overflow}, 32'd0);
    drive_bit(1'b1, 10);
    exp_busy = 1'b0;
    window(8);
    do_read();
    rx_frame(8'h12, 1'b0, 1'b1);
    window(8);
    chk("12_data", {24'd0, r_data}, 32'h12);
    chk("12_ferr", {31'd0, framing_err}, 32'd0);
    do_read();

    // Short glitch on the line.
    drive_bit(1'b0, 12);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 80);
    window(10);

    // Overflow and its clearing.
    rx_frame(8'h11, 1'b0, 1'b1);
    rx_frame(8'h22, 1'b0, 1'b1);
    window(8);
    chk("ovf_data", {24'd0, r_data}, 32'h11);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    do_read();
    window(4);
    rx_frame(8'h44, 1'b0, 1'b1);
    rx_frame(8'h55, 1'b0, 1'b1);
    window(4);
    fork
      send_frame(8'h66, 1'b0, 1'b1);
      rd_at_commit();
    join
    model_commit(8'h66, 1'b0, 1'b0, 1'b1);
    window(8);
    chk("rdcommit_data", {24'd0, r_data}, 32'h66);
    chk("rdcommit_ready", {31'd0, rx_ready}, 32'd1);
    chk("rdcommit_ovf", {31'd0, overflow}, 32'd0);

    // Reset during data bit 4 of 0xF0, with 0x66 still held.
    drive_bit(1'b0, 64);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 64);
    drive_bit(1'b1, 32);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_data", {24'd0, r_data}, 32'd0);
    chk("rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    model_reset();
    drive_bit(1'b1, 100);
    window(10);
    rx_frame(8'h81, 1'b0, 1'b1);
    window(8);
    chk("81_data", {24'd0, r_data}, 32'h81);
    chk("81_ready", {31'd0, rx_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
